dct_scale_round_sat_pipe: RTL and testbench
===========================================

Name: dct_scale_round_sat_pipe

Overview:
Next-generation output scaler for the DCT vector-rotation path. It takes wide complex samples from the rotation multiplier and right-shifts them by an amount derived from the FFT size. It then rounds with a selectable mode and saturates to W_OUT bits. It carries a full ready/valid pipeline with real backpressure, latches its per-frame configuration, and reports saturation counts per sample and per frame.

Parameters:
W_IN, 48, input sample width per component (signed two's complement)
W_OUT, 24, output sample width per component (signed)
BASE_SHIFT, 16, right shift applied at N = 2^LOG2_NMAX
LOG2_NMAX, 11, log2 of the largest supported FFT size
W_CNT, 12, width of the per-frame saturation counter

Ports:
clk  in  1  clock
rst_sync  in  1  synchronous reset, active-high
sink_valid  in  1  input beat valid
sink_ready  out  1  input beat accepted when sink_valid & sink_ready
sink_sop  in  1  first beat of frame
sink_eop  in  1  last beat of frame
sink_real  in  W_IN  real component
sink_imag  in  W_IN  imag component
fftpts_in  in  12  FFT size; sampled only on an accepted sop beat
round_mode  in  2  0 = round-half-up, 1 = truncate, 2 = convergent (half-even), 3 = same as 0; sampled on sop
source_valid  out  1  output beat valid
source_ready  in  1  downstream ready
source_sop  out  1  aligned sop
source_eop  out  1  aligned eop
source_real  out  W_OUT  scaled real component
source_imag  out  W_OUT  scaled imag component
fftpts_out  out  12  frame's latched fftpts, aligned with data
sat_flag  out  1  this output beat saturated (real or imag)
frame_sat_cnt  out  W_CNT  saturated-beat count of the frame; valid with frame_sat_valid
frame_sat_valid  out  1  one-cycle pulse on the transferred eop beat

Behaviour:
- Reset (rst_sync = 1 at clk edge):
  - Clears both stage valids, source_valid, sat_flag, frame_sat_valid, frame_sat_cnt, data outputs and fftpts_out.
  - Sets the latched shift to BASE_SHIFT and the latched mode to 0.
  - Drops any in-flight beat; there is no partial-frame recovery.
- Pipeline: two stages (S1 = capture/shift select, S2 = round/saturate); source_* registered from S2.
  - Latency is 2 cycles from an accepted beat to source_valid when there is no stall.
  - Full throughput is 1 beat/cycle.
- Handshake:
  - adv2 = !v2 | source_ready.
  - S2 loads when v1 & adv2.
  - sink_ready = !v1 | adv2; this is a combinational path from source_ready.
  - source_* must hold stable while source_valid & !source_ready.
  - No beat is lost or duplicated.
- Shift select, on an accepted sop beat:
  - L = log2(fftpts_in) for power-of-two values 16..2^LOG2_NMAX.
  - shift = BASE_SHIFT - floor((LOG2_NMAX - L)/2). With the defaults: 2048/1024 -> 16, 512/256 -> 15, 128/64 -> 14, 32/16 -> 13.
  - Any other fftpts value gives shift = BASE_SHIFT.
  - shift, round_mode and fftpts are latched and apply to every beat up to and including eop.
  - Beats before the first sop after reset use the reset values.
- Arithmetic, per component, x signed W_IN, s = shift:
  - t = x >>> s (arithmetic shift).
  - r = x[s-1].
  - st = OR of x[s-2:0].
  - Mode 0: y = t + r.
  - Mode 1: y = t.
  - Mode 2: y = t + (r & (st | t[0])).
  - y is computed at W_IN+1 bits, so the rounding carry never wraps.
  - If y > 2^(W_OUT-1)-1, the output is 0x7FFFFF (default width) and the component is marked saturated.
  - If y < -2^(W_OUT-1), the output is 0x800000 and the component is marked saturated.
  - Otherwise the output is y[W_OUT-1:0].
  - The saturation decision is made after rounding.
- sat_flag: the OR of the two component saturation marks. It is a true event, not a value compare; a legitimate full-scale result is not flagged.
- Frame counter:
  - Counts transferred output beats with sat_flag = 1.
  - Cleared to 0 on a transferred sop beat, then that beat's flag is added.
  - Saturates at 2^W_CNT-1.
- On a transferred eop beat:
  - frame_sat_valid = 1 for one cycle.
  - frame_sat_cnt = the total including that eop beat.
  - A beat with both sop and eop gives a count of 0 or 1.
- A sop without a preceding eop restarts the count with no error. An eop without sop still pulses with the running count.

Test Plan:
- fftpts = 2048, sop; real = 0x18000 (1.5) and 0x28000 (2.5): mode 0 -> 2, 3; mode 1 -> 1, 2; mode 2 -> 2, 2. Negative -0x18000: mode 0 -> -1, mode 2 -> -2.
- fftpts = 512 (shift 15): real = 0x7FFFFF<<15 -> 0x7FFFFF with sat_flag = 0. Same value + (1<<14), mode 0 -> 0x7FFFFF with sat_flag = 1 (rounding overflow).
- fftpts = 16 (shift 13): imag = -(1<<40) -> 0x800000 with sat_flag = 1. fftpts = 100 (illegal) -> shift 16 used.
- 16-beat frame streaming with source_ready low for cycles 3-7:
  - sink_ready falls once both stages are full.
  - Output order and values match the unstalled reference.
  - Exactly 16 output beats.
  - source_* stable while stalled.
- Two back-to-back 16-point frames, the first with 3 saturating beats: frame_sat_valid pulses on each eop with cnt = 3, then 0. fftpts changes on the second sop and is applied only from that beat.
- rst_sync pulsed mid-frame with data in flight: source_valid = 0 next cycle, no stale beat appears, counter = 0, and beats before the next sop use shift 16.

Source files
------------

// File: rtl/dct_scale_round_sat_pipe_if.sv
// -----------------------------------------------------------------------------
// dct_scale_round_sat_pipe_if
//   Bundle of the sink (input beat) and source (output beat) channels of the
//   DCT output scaler, including the per-frame configuration inputs and the
//   saturation status outputs.
//   Modports:
//     master : the side that produces input beats and consumes output beats
//     slave  : the scaler itself
// -----------------------------------------------------------------------------
interface dct_scale_round_sat_pipe_if #(
    parameter int W_IN  = 48,
    parameter int W_OUT = 24,
    parameter int W_CNT = 12
);
    // sink channel
    logic              sink_valid;
    logic              sink_ready;
    logic              sink_sop;
    logic              sink_eop;
    logic [W_IN-1:0]   sink_real;
    logic [W_IN-1:0]   sink_imag;
    logic [11:0]       fftpts_in;
    logic [1:0]        round_mode;

    // source channel
    logic              source_valid;
    logic              source_ready;
    logic              source_sop;
    logic              source_eop;
    logic [W_OUT-1:0]  source_real;
    logic [W_OUT-1:0]  source_imag;
    logic [11:0]       fftpts_out;
    logic              sat_flag;
    logic [W_CNT-1:0]  frame_sat_cnt;
    logic              frame_sat_valid;

    modport master (
        output sink_valid, sink_sop, sink_eop, sink_real, sink_imag,
               fftpts_in, round_mode, source_ready,
        input  sink_ready, source_valid, source_sop, source_eop,
               source_real, source_imag, fftpts_out, sat_flag,
               frame_sat_cnt, frame_sat_valid
    );

    modport slave (
        input  sink_valid, sink_sop, sink_eop, sink_real, sink_imag,
               fftpts_in, round_mode, source_ready,
        output sink_ready, source_valid, source_sop, source_eop,
               source_real, source_imag, fftpts_out, sat_flag,
               frame_sat_cnt, frame_sat_valid
    );
endinterface

// File: rtl/dct_scale_round_sat_pipe.sv
// -----------------------------------------------------------------------------
// dct_scale_round_sat_pipe
//   Output scaler for the DCT vector-rotation path. Each complex beat is
//   arithmetically right-shifted by an amount chosen from the frame's FFT
//   size, rounded (half-up / truncate / half-even) and saturated to W_OUT
//   bits. Two-stage ready/valid pipeline with full backpressure:
//     S1 : capture beat and the shift/mode that applies to it
//     S2 : round + saturate, registered straight onto the source channel
//   Ports:
//     clk      : clock
//     rst_sync : synchronous reset, active high
//     bus      : sink/source channels (slave modport), see the interface
//   Per-beat sat_flag and a per-frame saturated-beat count (pulsed with
//   frame_sat_valid on the transferred eop beat) are reported.
// -----------------------------------------------------------------------------
module dct_scale_round_sat_pipe #(
    parameter int W_IN       = 48,
    parameter int W_OUT      = 24,
    parameter int BASE_SHIFT = 16,
    parameter int LOG2_NMAX  = 11,
    parameter int W_CNT      = 12
) (
    input  logic                        clk,
    input  logic                        rst_sync,
    dct_scale_round_sat_pipe_if.slave   bus
);

    localparam int W_SH = $clog2(W_IN + 1);
    localparam logic [W_SH-1:0] BASE_SH = W_SH'(BASE_SHIFT);

    // Output range limits expressed at the W_IN+1 working width.
    localparam logic signed [W_IN:0] SMAX =
        $signed({{(W_IN-W_OUT+2){1'b0}}, {(W_OUT-1){1'b1}}});
    localparam logic signed [W_IN:0] SMIN =
        $signed({{(W_IN-W_OUT+2){1'b1}}, {(W_OUT-1){1'b0}}});
    localparam logic [W_OUT-1:0] OMAX = {1'b0, {(W_OUT-1){1'b1}}};
    localparam logic [W_OUT-1:0] OMIN = {1'b1, {(W_OUT-1){1'b0}}};

    // Shift for a given FFT size. Every halving pair of sizes below the
    // maximum drops the shift by one; non power-of-two or out-of-range
    // sizes fall back to the base shift.
    function automatic logic [W_SH-1:0] shift_sel(input logic [11:0] pts);
        logic [W_SH-1:0] s;
        s = BASE_SH;
        for (int l = 4; l <= LOG2_NMAX; l++) begin
            if (pts == 12'(1 << l))
                s = W_SH'(BASE_SHIFT - (LOG2_NMAX - l) / 2);
        end
        return s;
    endfunction

    // Shift, round and saturate one component.
    // Returns {saturated, value}. Shift is assumed to be at least 2.
    function automatic logic [W_OUT:0] round_sat(
        input logic signed [W_IN-1:0] x,
        input logic [W_SH-1:0]        s,
        input logic [1:0]             mode
    );
        logic signed [W_IN:0] xe;
        logic signed [W_IN:0] t;
        logic signed [W_IN:0] y;
        logic [W_IN:0]        low_mask;
        logic [W_SH-1:0]      sm1;
        logic                 r;
        logic                 st;
        logic                 inc;
        xe       = {x[W_IN-1], x};
        sm1      = s - 1'b1;
        t        = xe >>> s;
        r        = xe[sm1];
        // sticky = any bit strictly below the rounding bit
        low_mask = ~({(W_IN+1){1'b1}} << sm1);
        st       = |($unsigned(xe) & low_mask);
        case (mode)
            2'd1:    inc = 1'b0;
            2'd2:    inc = r & (st | t[0]);
            default: inc = r;
        endcase
        // One extra bit of headroom keeps the rounding carry from wrapping;
        // the range check therefore sees the rounded value.
        y = t + $signed({{W_IN{1'b0}}, inc});
        if (y > SMAX)
            return {1'b1, OMAX};
        else if (y < SMIN)
            return {1'b1, OMIN};
        else
            return {1'b0, y[W_OUT-1:0]};
    endfunction

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    logic v1;
    logic adv2;
    logic accept;
    logic xfer;

    assign adv2           = !bus.source_valid | bus.source_ready;
    assign bus.sink_ready = !v1 | adv2;
    assign accept         = bus.sink_valid & bus.sink_ready;
    assign xfer           = bus.source_valid & bus.source_ready;

    // -------------------------------------------------------------------------
    // Frame configuration: a sop beat uses its own fftpts/mode immediately,
    // and they persist for the rest of the frame.
    // -------------------------------------------------------------------------
    logic [W_SH-1:0] cfg_shift;
    logic [1:0]      cfg_mode;
    logic [11:0]     cfg_pts;
    logic [W_SH-1:0] beat_shift;
    logic [1:0]      beat_mode;
    logic [11:0]     beat_pts;

    always_comb begin
        beat_shift = cfg_shift;
        beat_mode  = cfg_mode;
        beat_pts   = cfg_pts;
        if (bus.sink_sop) begin
            beat_shift = shift_sel(bus.fftpts_in);
            beat_mode  = bus.round_mode;
            beat_pts   = bus.fftpts_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            cfg_shift <= BASE_SH;
            cfg_mode  <= 2'd0;
            cfg_pts   <= '0;
        end else if (accept && bus.sink_sop) begin
            cfg_shift <= beat_shift;
            cfg_mode  <= beat_mode;
            cfg_pts   <= beat_pts;
        end
    end

    // -------------------------------------------------------------------------
    // S1: capture
    // -------------------------------------------------------------------------
    logic signed [W_IN-1:0] s1_re;
    logic signed [W_IN-1:0] s1_im;
    logic                   s1_sop;
    logic                   s1_eop;
    logic [W_SH-1:0]        s1_shift;
    logic [1:0]             s1_mode;
    logic [11:0]            s1_pts;

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            v1       <= 1'b0;
            s1_re    <= '0;
            s1_im    <= '0;
            s1_sop   <= 1'b0;
            s1_eop   <= 1'b0;
            s1_shift <= BASE_SH;
            s1_mode  <= 2'd0;
            s1_pts   <= '0;
        end else if (bus.sink_ready) begin
            // S1 is empty or draining this cycle, so it can take a new beat
            v1 <= bus.sink_valid;
            if (bus.sink_valid) begin
                s1_re    <= $signed(bus.sink_real);
                s1_im    <= $signed(bus.sink_imag);
                s1_sop   <= bus.sink_sop;
                s1_eop   <= bus.sink_eop;
                s1_shift <= beat_shift;
                s1_mode  <= beat_mode;
                s1_pts   <= beat_pts;
            end
        end
    end

    // -------------------------------------------------------------------------
    // S2: round / saturate, registered onto the source channel
    // -------------------------------------------------------------------------
    logic [W_OUT:0] rs_re;
    logic [W_OUT:0] rs_im;

    assign rs_re = round_sat(s1_re, s1_shift, s1_mode);
    assign rs_im = round_sat(s1_im, s1_shift, s1_mode);

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            bus.source_valid <= 1'b0;
            bus.source_sop   <= 1'b0;
            bus.source_eop   <= 1'b0;
            bus.source_real  <= '0;
            bus.source_imag  <= '0;
            bus.fftpts_out   <= '0;
            bus.sat_flag     <= 1'b0;
        end else if (adv2) begin
            bus.source_valid <= v1;
            if (v1) begin
                bus.source_sop  <= s1_sop;
                bus.source_eop  <= s1_eop;
                bus.source_real <= rs_re[W_OUT-1:0];
                bus.source_imag <= rs_im[W_OUT-1:0];
                bus.fftpts_out  <= s1_pts;
                bus.sat_flag    <= rs_re[W_OUT] | rs_im[W_OUT];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Per-frame saturation counter, advanced only on transferred beats
    // -------------------------------------------------------------------------
    logic [W_CNT-1:0] run_cnt;
    logic [W_CNT-1:0] cnt_base;
    logic [W_CNT-1:0] cnt_next;

    always_comb begin
        cnt_base = bus.source_sop ? '0 : run_cnt;
        cnt_next = cnt_base;
        if (bus.sat_flag && cnt_base != {W_CNT{1'b1}})
            cnt_next = cnt_base + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            run_cnt             <= '0;
            bus.frame_sat_cnt   <= '0;
            bus.frame_sat_valid <= 1'b0;
        end else begin
            bus.frame_sat_valid <= 1'b0;
            if (xfer) begin
                run_cnt <= cnt_next;
                if (bus.source_eop) begin
                    bus.frame_sat_cnt   <= cnt_next;
                    bus.frame_sat_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dct_scale_round_sat_pipe.sv
module tb_dct_scale_round_sat_pipe;
    localparam int W_IN  = 48;
    localparam int W_OUT = 24;
    localparam int W_CNT = 12;

    logic clk = 1'b0;
    logic rst_sync;
    always #5 clk = ~clk;

    dct_scale_round_sat_pipe_if #(.W_IN(W_IN), .W_OUT(W_OUT), .W_CNT(W_CNT)) bus ();

    dct_scale_round_sat_pipe #(
        .W_IN(W_IN), .W_OUT(W_OUT), .BASE_SHIFT(16), .LOG2_NMAX(11), .W_CNT(W_CNT)
    ) dut (
        .clk(clk),
        .rst_sync(rst_sync),
        .bus(bus)
    );

    typedef struct packed {
        logic [23:0] re;
        logic [23:0] im;
        logic        sop;
        logic        eop;
        logic        sat;
        logic [11:0] pts;
    } exp_t;

    exp_t             exq[$];
    logic [W_CNT-1:0] fq[$];
    int n_chk  = 0;
    int n_fail = 0;
    int n_out  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s", nm);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        exp_t e;
        exp_t cur;
        exp_t prev;
        logic prev_stall;
        prev_stall = 1'b0;
        prev       = '0;
        forever begin
            @(negedge clk);
            cur = {bus.source_real, bus.source_imag, bus.source_sop,
                   bus.source_eop, bus.sat_flag, bus.fftpts_out};
            if (rst_sync) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && bus.source_valid)
                    chk("hold_stable", cur, prev);
                if (bus.source_valid && bus.source_ready) begin
                    n_out++;
                    if (exq.size() == 0) begin
                        fail_now("unexpected_output_beat");
                    end else begin
                        e = exq.pop_front();
                        chk("beat_real", bus.source_real, e.re);
                        chk("beat_imag", bus.source_imag, e.im);
                        chk("beat_ctl_sop_eop_sat_pts",
                            {bus.source_sop, bus.source_eop, bus.sat_flag, bus.fftpts_out},
                            {e.sop, e.eop, e.sat, e.pts});
                    end
                end
                prev_stall = bus.source_valid & !bus.source_ready;
                prev       = cur;
                if (bus.frame_sat_valid) begin
                    if (fq.size() == 0) fail_now("unexpected_frame_pulse");
                    else chk("frame_sat_cnt", bus.frame_sat_cnt, fq.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at a negedge; returns at the negedge after the beat is accepted.
    task automatic send(input logic sop, input logic eop,
                        input logic [47:0] re, input logic [47:0] im,
                        input logic [11:0] pts, input logic [1:0] mode,
                        input logic [23:0] ere, input logic [23:0] eim,
                        input logic esat, input logic [11:0] epts,
                        input logic [W_CNT-1:0] efc);
        int k;
        bus.sink_valid = 1'b1;
        bus.sink_sop   = sop;
        bus.sink_eop   = eop;
        bus.sink_real  = re;
        bus.sink_imag  = im;
        bus.fftpts_in  = pts;
        bus.round_mode = mode;
        k = 0;
        while (!bus.sink_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!bus.sink_ready) begin
            fail_now("sink_ready_timeout");
            bus.sink_valid = 1'b0;
            return;
        end
        exq.push_back({ere, eim, sop, eop, esat, epts});
        if (eop) fq.push_back(efc);
        @(posedge clk);
        @(negedge clk);
        bus.sink_valid = 1'b0;
    endtask

    task automatic one(input logic [47:0] re, input logic [47:0] im,
                       input logic [11:0] pts, input logic [1:0] mode,
                       input logic [23:0] ere, input logic [23:0] eim,
                       input logic esat);
        send(1'b1, 1'b1, re, im, pts, mode, ere, eim, esat, pts, W_CNT'(esat));
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exq.size() != 0 || fq.size() != 0) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (exq.size() != 0 || fq.size() != 0) fail_now("drain_timeout");
        repeat (2) @(negedge clk);
    endtask

    // ---------------- main stimulus ----------------
    initial begin
        int out0;
        logic [47:0] v;
        rst_sync         = 1'b1;
        bus.sink_valid   = 1'b0;
        bus.sink_sop     = 1'b0;
        bus.sink_eop     = 1'b0;
        bus.sink_real    = '0;
        bus.sink_imag    = '0;
        bus.fftpts_in    = '0;
        bus.round_mode   = '0;
        bus.source_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_source_valid", bus.source_valid, 0);
        chk("rst_sat_flag", bus.sat_flag, 0);
        chk("rst_frame_sat_valid", bus.frame_sat_valid, 0);
        chk("rst_frame_sat_cnt", bus.frame_sat_cnt, 0);
        chk("rst_source_real", bus.source_real, 0);
        chk("rst_fftpts_out", bus.fftpts_out, 0);
        rst_sync = 1'b0;
        @(negedge clk);
        chk("idle_sink_ready", bus.sink_ready, 1);

        // Beat before any sop: reset config (shift 16, mode 0, pts 0)
        send(1'b0, 1'b1, 48'h18000, 48'h0, 12'd16, 2'd1, 24'd2, 24'd0, 1'b0, 12'd0, 0);

        // Rounding modes at shift 16
        one(48'h18000, 48'h0, 12'd2048, 2'd0, 24'd2, 24'd0, 1'b0);
        one(48'h28000, 48'h0, 12'd2048, 2'd0, 24'd3, 24'd0, 1'b0);
        one(48'h18000, 48'h0, 12'd2048, 2'd1, 24'd1, 24'd0, 1'b0);
        one(48'h28000, 48'h0, 12'd2048, 2'd1, 24'd2, 24'd0, 1'b0);
        one(48'h18000, 48'h0, 12'd2048, 2'd2, 24'd2, 24'd0, 1'b0);
        one(48'h28000, 48'h0, 12'd2048, 2'd2, 24'd2, 24'd0, 1'b0);
        one(48'hFFFF_FFFE_8000, 48'h0, 12'd2048, 2'd0, 24'hFFFFFF, 24'd0, 1'b0);
        one(48'hFFFF_FFFE_8000, 48'h0, 12'd2048, 2'd2, 24'hFFFFFE, 24'd0, 1'b0);
        one(48'h28001, 48'h0, 12'd2048, 2'd2, 24'd3, 24'd0, 1'b0);
        one(48'h28000, 48'h0, 12'd2048, 2'd3, 24'd3, 24'd0, 1'b0);
        // Shift table
        one(48'h18000, 48'h0, 12'd1024, 2'd0, 24'd2, 24'd0, 1'b0);
        one(48'h18000, 48'h0, 12'd256, 2'd1, 24'd3, 24'd0, 1'b0);
        one(48'h14000, 48'h0, 12'd64, 2'd1, 24'd5, 24'd0, 1'b0);
        one(48'h18000, 48'h0, 12'd32, 2'd1, 24'd12, 24'd0, 1'b0);
        one(48'h18000, 48'h0, 12'd100, 2'd0, 24'd2, 24'd0, 1'b0);
        // Full-scale legit vs rounding overflow at shift 15
        send(1'b1, 1'b0, 48'h3F_FFFF_8000, 48'h0, 12'd512, 2'd0,
             24'h7FFFFF, 24'd0, 1'b0, 12'd512, 0);
        send(1'b0, 1'b1, 48'h3F_FFFF_C000, 48'h0, 12'd16, 2'd1,
             24'h7FFFFF, 24'd0, 1'b1, 12'd512, 1);
        // Negative saturation at shift 13
        one(48'h6000, 48'hFF00_0000_0000, 12'd16, 2'd1, 24'd3, 24'h800000, 1'b1);
        drain();

        // 16-beat frame with a 5-cycle output stall
        out0 = n_out;
        fork
            begin
                for (int i = 0; i < 16; i++)
                    send(i == 0, i == 15, 48'(i + 1) << 13, -(48'(i) << 13),
                         12'd16, 2'd1, 24'(i + 1), 24'(-i), 1'b0, 12'd16, 0);
            end
            begin
                repeat (3) @(posedge clk);
                #1 bus.source_ready = 1'b0;
                repeat (2) @(negedge clk);
                chk("stall_sink_ready_low", bus.sink_ready, 0);
                chk("stall_source_valid", bus.source_valid, 1);
                repeat (4) @(posedge clk);
                #1 bus.source_ready = 1'b1;
            end
        join
        drain();
        chk("stall_frame_beats", n_out - out0, 16);

        // Back-to-back frames: 3 saturating beats, then clean frame at new size
        for (int i = 0; i < 16; i++) begin
            if (i == 2 || i == 5 || i == 9)
                send(i == 0, i == 15, 48'h0100_0000_0000, 48'h0, 12'd16, 2'd0,
                     24'h7FFFFF, 24'd0, 1'b1, 12'd16, 3);
            else
                send(i == 0, i == 15, 48'(i) << 13, 48'h0, 12'd16, 2'd0,
                     24'(i), 24'd0, 1'b0, 12'd16, 3);
        end
        for (int i = 0; i < 16; i++)
            send(i == 0, i == 15, 48'(i + 1) << 16, 48'h0, 12'd2048, 2'd0,
                 24'(i + 1), 24'd0, 1'b0, 12'd2048, 0);
        drain();

        // Mid-frame reset with beats in flight
        send(1'b1, 1'b0, 48'h0100_0000_0000, 48'h0, 12'd16, 2'd1,
             24'h7FFFFF, 24'd0, 1'b1, 12'd16, 0);
        drain();
        bus.source_ready = 1'b0;
        v = 48'h2000;
        send(1'b0, 1'b0, v, 48'h0, 12'd16, 2'd1, 24'd1, 24'd0, 1'b0, 12'd16, 0);
        send(1'b0, 1'b0, v, 48'h0, 12'd16, 2'd1, 24'd1, 24'd0, 1'b0, 12'd16, 0);
        rst_sync = 1'b1;
        exq.delete();
        fq.delete();
        @(negedge clk);
        chk("midrst_source_valid", bus.source_valid, 0);
        chk("midrst_sink_ready", bus.sink_ready, 1);
        chk("midrst_frame_sat_cnt", bus.frame_sat_cnt, 0);
        rst_sync = 1'b0;
        bus.source_ready = 1'b1;
        @(negedge clk);
        send(1'b0, 1'b1, 48'h18000, 48'h0, 12'd16, 2'd1, 24'd2, 24'd0, 1'b0, 12'd0, 0);
        drain();

        chk("no_leftover_beats", exq.size(), 0);
        chk("no_leftover_frames", fq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end
endmodule
